// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed 32-bit multiply/divide sequencer for the execute stage.
// Every add, subtract and negate goes through one shared adder_subtractor.

module adder_subtractor (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        add_sub,
    output logic [31:0] sum,
    output logic        c_out
);
    logic [31:0] b_eff_s;

    assign b_eff_s = add_sub ? ~b : b;
    // add_sub=1 yields a - b with c_out=1 meaning no borrow
    assign {c_out, sum} = {1'b0, a} + {1'b0, b_eff_s} + {32'd0, add_sub};
endmodule

module multdiv_sequencer #(
    parameter int ITERS = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS_A = 3'd1,
        ABS_B = 3'd2,
        ITER  = 3'd3,
        FIX   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_r;
    logic [31:0] op_a_r;
    logic [31:0] op_b_r;
    logic        is_div_r;
    logic [31:0] mag_a_r;
    logic [31:0] mag_b_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [4:0]  cnt_r;
    logic [31:0] result_r;
    logic        exception_r;
    logic        rdy_r;
    logic        busy_r;

    logic [31:0] add_a_s;
    logic [31:0] add_b_s;
    logic        add_sub_s;
    logic [31:0] add_sum_s;
    logic        add_c_out_s;
    logic [31:0] div_shift_s;
    logic        start_s;
    logic        fix_neg_s;
    logic [31:0] fix_res_s;
    logic        fix_exc_s;

    assign start_s        = ctrl_MULT | ctrl_DIV;
    assign data_result    = result_r;
    assign data_exception = exception_r;
    assign data_resultRDY = rdy_r;
    assign busy           = busy_r;

    adder_subtractor u_adder_subtractor (
        .a       (add_a_s),
        .b       (add_b_s),
        .add_sub (add_sub_s),
        .sum     (add_sum_s),
        .c_out   (add_c_out_s)
    );

    // Partial remainder shifted left by one, pulling in the next dividend bit
    always_comb begin
        div_shift_s = {hi_r[30:0], lo_r[31]};
    end

    // Operand steering for the shared adder in each state
    always_comb begin
        add_a_s   = 32'd0;
        add_b_s   = 32'd0;
        add_sub_s = 1'b0;
        case (state_r)
            ABS_A: begin
                add_b_s   = op_a_r;
                add_sub_s = 1'b1;
            end
            ABS_B: begin
                add_b_s   = op_b_r;
                add_sub_s = 1'b1;
            end
            ITER: begin
                if (is_div_r) begin
                    add_a_s   = div_shift_s;
                    add_b_s   = mag_b_r;
                    add_sub_s = 1'b1;
                end else begin
                    add_a_s   = hi_r;
                    add_b_s   = mag_a_r;
                    add_sub_s = 1'b0;
                end
            end
            FIX: begin
                add_b_s   = lo_r;
                add_sub_s = 1'b1;
            end
            default: begin
                add_a_s   = 32'd0;
                add_b_s   = 32'd0;
                add_sub_s = 1'b0;
            end
        endcase
    end

    // Sign fix-up and overflow / divide-by-zero evaluation
    always_comb begin
        fix_neg_s = op_a_r[31] ^ op_b_r[31];
        if (fix_neg_s) begin
            fix_res_s = add_sum_s;
        end else begin
            fix_res_s = lo_r;
        end
        if (is_div_r) begin
            if (mag_b_r == 32'd0) begin
                fix_exc_s = 1'b1;
                fix_res_s = 32'd0;
            end else begin
                // only 0x80000000 / -1 produces a positive quotient of 2^31
                fix_exc_s = ~fix_neg_s & lo_r[31];
            end
        end else begin
            if (hi_r != 32'd0) begin
                fix_exc_s = 1'b1;
            end else if (fix_neg_s) begin
                fix_exc_s = (lo_r > 32'h8000_0000);
            end else begin
                fix_exc_s = lo_r[31];
            end
        end
    end

    // Sequencer FSM with registered outputs; a start pulse restarts from any state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            op_a_r      <= 32'd0;
            op_b_r      <= 32'd0;
            is_div_r    <= 1'b0;
            mag_a_r     <= 32'd0;
            mag_b_r     <= 32'd0;
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
            cnt_r       <= 5'd0;
            result_r    <= 32'd0;
            exception_r <= 1'b0;
            rdy_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else if (start_s) begin
            state_r  <= ABS_A;
            op_a_r   <= data_operandA;
            op_b_r   <= data_operandB;
            is_div_r <= ~ctrl_MULT;
            rdy_r    <= 1'b0;
            busy_r   <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    rdy_r  <= 1'b0;
                    busy_r <= 1'b0;
                end
                ABS_A: begin
                    mag_a_r <= op_a_r[31] ? add_sum_s : op_a_r;
                    state_r <= ABS_B;
                end
                ABS_B: begin
                    mag_b_r <= op_b_r[31] ? add_sum_s : op_b_r;
                    hi_r    <= 32'd0;
                    lo_r    <= is_div_r ? mag_a_r : (op_b_r[31] ? add_sum_s : op_b_r);
                    cnt_r   <= 5'd0;
                    state_r <= ITER;
                end
                ITER: begin
                    if (is_div_r) begin
                        if (add_c_out_s) begin
                            hi_r <= add_sum_s;
                            lo_r <= {lo_r[30:0], 1'b1};
                        end else begin
                            hi_r <= div_shift_s;
                            lo_r <= {lo_r[30:0], 1'b0};
                        end
                    end else begin
                        if (lo_r[0]) begin
                            hi_r <= {add_c_out_s, add_sum_s[31:1]};
                            lo_r <= {add_sum_s[0], lo_r[31:1]};
                        end else begin
                            hi_r <= {1'b0, hi_r[31:1]};
                            lo_r <= {hi_r[0], lo_r[31:1]};
                        end
                    end
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'(ITERS - 1)) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= ITER;
                    end
                end
                FIX: begin
                    result_r    <= fix_res_s;
                    exception_r <= fix_exc_s;
                    rdy_r       <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= DONE;
                end
                DONE: begin
                    rdy_r   <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    rdy_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed self-checking bench for multdiv_sequencer.

module tb_multdiv_sequencer;
    logic        clock;
    logic        reset_n;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks;
    int failures;
    int lat;
    int busy_cnt;
    int rdy_cnt;

    multdiv_sequencer #(.ITERS(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse; returns right after the start edge (E0 + 1)
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Count cycles to RDY (bounded), and cycles busy was high before it
    task automatic wait_rdy(output int cycles, output int bcnt);
        cycles = -1;
        bcnt   = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                cycles = i;
                break;
            end
            if (busy === 1'b1) bcnt++;
        end
    endtask

    task automatic count_rdy(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) cnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc);
        start_op(m, d, a, b);
        check({tag, "_busy_start"}, 64'(busy), 64'd1);
        wait_rdy(lat, busy_cnt);
        check({tag, "_latency"}, 64'(lat), 64'd35);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd34);
        check({tag, "_busy_in_rdy"}, 64'(busy), 64'd0);
        check({tag, "_result"}, 64'(data_result), 64'(exp_res));
        check({tag, "_exc"}, 64'(data_exception), 64'(exp_exc));
        @(posedge clock);
        #1;
        check({tag, "_rdy_width"}, 64'(data_resultRDY), 64'd0);
        check({tag, "_result_hold"}, 64'(data_result), 64'(exp_res));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_result", 64'(data_result), 64'd0);
        check("rst_exc", 64'(data_exception), 64'd0);
        check("rst_rdy", 64'(data_resultRDY), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run_op("mul_min_1", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
        run_op("mul_min_m1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op("div_100_m10", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0);
        run_op("div_by_0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
        run_op("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

        // Restart: DIV aborted by a MULT ten cycles later
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        count_rdy(9, rdy_cnt);
        check("abort_no_early_rdy", 64'(rdy_cnt), 64'd0);
        run_op("abort_mul_3_4", 1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0);
        count_rdy(40, rdy_cnt);
        check("abort_single_rdy", 64'(rdy_cnt), 64'd0);

        run_op("both_ctrl", 1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0);

        // Asynchronous reset in the middle of a MULT
        start_op(1'b1, 1'b0, 32'd5, 32'd6);
        repeat (19) @(posedge clock);
        #2;
        check("pre_rst_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_result", 64'(data_result), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_rdy", 64'(data_resultRDY), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        count_rdy(40, rdy_cnt);
        check("no_rdy_after_rst", 64'(rdy_cnt), 64'd0);
        run_op("div_9_3", 1'b0, 1'b1, 32'd9, 32'd3, 32'd3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Multi-cycle signed 32-bit multiply/divide unit for the processor's execute stage.
- Time-shares a single 32-bit adder_subtractor instance for every add, subtract and negate; no other full-width adder in the block.
- Started by a one-cycle ctrl pulse from the pipeline; returns a result with a one-cycle ready pulse and an exception flag; the pipeline stalls on busy.

Parameters:
- ITERS, 32, iteration count; must equal the adder width (32). Any other value is unsupported.

Ports:
- clock  input  1  single clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- ctrl_MULT  input  1  one-cycle start pulse: signed multiply
- ctrl_DIV  input  1  one-cycle start pulse: signed divide
- data_operandA  input  32  multiplicand / dividend, sampled on start edge only
- data_operandB  input  32  multiplier / divisor, sampled on start edge only
- data_result  output  32  result register
- data_exception  output  1  overflow or divide-by-zero flag
- data_resultRDY  output  1  one-cycle result-valid pulse
- busy  output  1  high while an operation is in flight

Behaviour:
- Reset (reset_n low, async): state IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0; all internal registers cleared. Reset mid-operation aborts it; no RDY pulse is produced for the aborted op.
- States: IDLE, ABS_A, ABS_B, ITER, FIX, DONE.
- Start: on any edge where ctrl_MULT or ctrl_DIV=1, operands and op type are latched and state goes to ABS_A. This applies in every state: a new start aborts the current op and restarts, with no RDY for the aborted op.
- Start conflict: ctrl_MULT and ctrl_DIV both high selects MULT; DIV is ignored.
- ABS_A: adder computes 0 - A; the magnitude register takes that result if A[31]=1, else A. One cycle.
- ABS_B: the same for B. One cycle.
- ITER: exactly 32 cycles, with a 5-bit iteration counter.
  - MULT: radix-2 shift-add over the 64-bit unsigned magnitude product. The adder adds |A| into the upper half when the current multiplier LSB=1.
  - DIV: restoring division. The adder computes remainder - |B| with add_sub=1. If c_out=1, accept the difference and shift in quotient bit 1; else keep the remainder and shift in 0.
- FIX: one cycle. Result sign is A[31]^B[31]. If negative, the adder computes 0 - magnitude. Exception is evaluated here.
- DONE: data_result and data_exception are registered. data_resultRDY=1 for exactly this one cycle. Return to IDLE.
- Latency is fixed and data-independent: 35 cycles. Start sampled at edge E0 gives RDY high from E35 to E36. busy is high from E0 to E35 and low in the RDY cycle.
- MULT exception: P = 64-bit magnitude product. Set if P[63:32]≠0, or P[31:0] > 2^31 (negative result), or P[31:0] ≥ 2^31 (positive result). data_result is the low 32 bits of the signed product regardless of exception.
- DIV: quotient truncates toward zero; the remainder is discarded.
  - Divisor 0: exception=1, result=0, full 35-cycle latency still applies.
  - 0x80000000 / 0xFFFFFFFF: exception=1, result=0x80000000.
- Magnitude of 0x80000000 is 0x80000000 taken as unsigned 2^31; no special case is needed.
- data_result and data_exception hold their values until the next DONE.
- Operand inputs are ignored after the start edge.

Test Plan:
- Reset release, then MULT A=7, B=0xFFFFFFFD (-3) → RDY exactly 35 cycles after start, result 0xFFFFFFEB, exc 0. busy high for 35 cycles; RDY high for 1 cycle.
- MULT A=0x00010000, B=0x00010000 → result 0x00000000, exc 1. Then MULT A=0x80000000, B=1 → 0x80000000, exc 0. Then MULT A=0x80000000, B=0xFFFFFFFF → exc 1.
- DIV A=0xFFFFFFF9 (-7), B=2 → 0xFFFFFFFD, exc 0. Then DIV A=100, B=0xFFFFFFF6 (-10) → 0xFFFFFFF6, exc 0.
- DIV A=5, B=0 → result 0, exc 1 at cycle 35. Then DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000, exc 1.
- DIV 100/7 started, then ctrl_MULT with A=3, B=4 pulsed 10 cycles later → exactly one RDY pulse, 35 cycles after the MULT start, result 12. Simultaneous ctrl_MULT and ctrl_DIV with A=6, B=3 → result 18.
- reset_n driven low at cycle 20 of a MULT → outputs 0 immediately (asynchronously) and no RDY afterwards. After release, a new DIV 9/3 → result 3.
